rvb_pcpi_master: RTL
====================

RVB_PCPI_MASTER -- requirements
Module: rvb_pcpi_master

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: the number of consecutive cycles with pcpi_valid=1 and both pcpi_wait=0 and pcpi_ready=0 after which the instruction is declared illegal; legal range is 2..255.
REQ-002 SHALL have these ports:
- clk  in  1  clock; all state changes on the rising edge.
- resetn  in  1  reset, synchronous, active-low.
- req_valid  in  1  instruction request valid.
- req_ready  out  1  request accepted.
- req_insn  in  32  instruction word.
- req_rs1, req_rs2, req_rs3  in  32 each  operand values.
- pcpi_valid  out  1  coprocessor request.
- pcpi_insn  out  32  instruction driven to the coprocessor.
- pcpi_rs1, pcpi_rs2, pcpi_rs3  out  32 each  operands driven to the coprocessor.
- pcpi_wr  in  1  coprocessor writes rd.
- pcpi_rd  in  32  coprocessor result.
- pcpi_wait  in  1  coprocessor claims the instruction and needs more cycles.
- pcpi_ready  in  1  coprocessor result valid.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accepted.
- rsp_rd  out  32  result value.
- rsp_wr  out  1  rd write enable.
- rsp_illegal  out  1  no coprocessor claimed the instruction.

Function
REQ-003 SHALL implement an FSM with three states: IDLE, ISSUE and RESP.
REQ-004 In IDLE, req_ready SHALL be 1; in every other state req_ready SHALL be 0.
REQ-005 When req_valid=1 and req_ready=1, the block SHALL register insn/rs1/rs2/rs3 and enter ISSUE; pcpi_valid SHALL rise on the next cycle (registered, no combinational path from req_valid).
REQ-006 In ISSUE, pcpi_valid SHALL be 1 and pcpi_insn/rs1/rs2/rs3 SHALL be held stable.
REQ-007 In ISSUE, a watchdog counter SHALL:
- clear on any cycle with pcpi_wait=1;
- otherwise increment each cycle.
REQ-008 pcpi_ready=1 in ISSUE SHALL cause the following at the same edge:
- capture rsp_rd <= pcpi_rd, rsp_wr <= pcpi_wr, rsp_illegal <= 0;
- move to RESP;
- drive pcpi_valid to 0.
pcpi_valid SHALL therefore be asserted for no more than one cycle after the pcpi_ready sample.
REQ-009 When the watchdog reaches TIMEOUT-1 with pcpi_wait=0 and pcpi_ready=0, the block SHALL enter RESP with rsp_illegal=1, rsp_wr=0 and rsp_rd=0, and pcpi_valid SHALL drop.
REQ-010 If pcpi_ready=1 and the timeout condition occur in the same cycle, pcpi_ready SHALL win.
REQ-011 pcpi_wait held high indefinitely SHALL never time out.
REQ-012 In RESP, rsp_valid SHALL be 1 and rsp_rd/rsp_wr/rsp_illegal SHALL be held stable until rsp_ready=1; on that handshake the block SHALL return to IDLE.
REQ-013 Worst-case latency from acceptance to rsp_valid SHALL be TIMEOUT+1 cycles absent pcpi_wait; with immediate pcpi_ready it SHALL be 2 cycles.
REQ-014 pcpi_wr and pcpi_rd SHALL be ignored outside cycles with pcpi_ready=1 in ISSUE.
REQ-015 A pcpi_ready seen in IDLE or RESP SHALL be ignored.

Reset
REQ-016 While resetn=0 at a rising edge, the block SHALL enter IDLE, with these outputs:
- pcpi_valid=0, rsp_valid=0, rsp_wr=0, rsp_illegal=0;
- rsp_rd=0 and the pcpi_* data outputs=0;
- watchdog=0.
REQ-017 Reset during ISSUE or RESP SHALL abandon the transaction silently, with no response; pcpi_valid SHALL be 0 in the cycle after the reset edge.

Configuration
REQ-018 With RVB_PCPI_MASTER_STATS_EN defined, the block SHALL add three 32-bit outputs:
- stat_issued: counts request handshakes;
- stat_illegal: counts timeouts;
- stat_wait_cycles: counts ISSUE cycles with pcpi_wait=1.
All three SHALL wrap modulo 2^32 and reset to 0.
REQ-019 Without RVB_PCPI_MASTER_STATS_EN, these ports and counters SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-020 Package rvb_pcpi_pkg SHALL hold:
- the FSM state enum;
- the XLEN=32 constant;
- a response struct (rd, wr, illegal).
REQ-021 The watchdog SHALL be a sub-module, rvb_pcpi_watchdog, with these ports and parameter:
- inputs: clk, resetn, run, clear;
- output: expired;
- parameter TIMEOUT.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Basic result: request insn=0x40005033, rs1=0x0000FF00; responder gives pcpi_ready+pcpi_wr with rd=0x00FF0000 on the first ISSUE cycle -> rsp_valid 2 cycles after acceptance, rsp_rd=0x00FF0000, rsp_wr=1, rsp_illegal=0, pcpi_valid high exactly 1 cycle.
- Long wait: responder holds pcpi_wait for 100 cycles, then gives ready with rd=0x12345678 -> no timeout, rsp_rd=0x12345678.
- No responder (TIMEOUT=16) -> rsp_valid at cycle 17 after acceptance, rsp_illegal=1, rsp_wr=0, rsp_rd=0.
- Collision: pcpi_ready coincides with the watchdog reaching TIMEOUT-1 -> rsp_illegal=0.
- Backpressure: rsp_ready=0 for 5 cycles -> rsp fields stable, req_ready=0, and no second pcpi_valid pulse.
- Reset in ISSUE: resetn=0 for 1 cycle while in ISSUE -> pcpi_valid=0 and rsp_valid=0 next cycle; then a fresh request completes normally; with STATS_EN, stat_issued=1 after reset.

Source files
------------

// File: rtl/rvb_pcpi_pkg.sv
// ============================================================================
// rvb_pcpi_pkg : shared types for the PCPI master (state enum, XLEN, response)
// Revision: 1.0
// ============================================================================
`default_nettype none

package rvb_pcpi_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0] rd;
    logic            wr;
    logic            illegal;
  } rsp_t;

endpackage

`default_nettype wire

// File: rtl/rvb_pcpi_watchdog.sv
// ============================================================================
// rvb_pcpi_watchdog : counts idle ISSUE cycles, flags expiry at TIMEOUT-1
// Revision: 1.0
// ============================================================================
`default_nettype none

module rvb_pcpi_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic resetn,
  input  logic run,
  input  logic clear,
  output logic expired
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] count_q;
  logic [7:0] count_d;

  always_comb begin
    count_d = count_q;
    if (!run || clear) begin
      count_d = '0;
    end else if (count_q != LAST) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = run && !clear && (count_q == LAST);

endmodule

`default_nettype wire

// File: rtl/rvb_pcpi_master.sv
// ============================================================================
// rvb_pcpi_master : issues one instruction to PCPI coprocessors, returns result
// or an illegal flag on timeout. Optional counters: RVB_PCPI_MASTER_STATS_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rvb_pcpi_master
  import rvb_pcpi_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_insn,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  input  logic [XLEN-1:0] req_rs3,
  output logic            pcpi_valid,
  output logic [XLEN-1:0] pcpi_insn,
  output logic [XLEN-1:0] pcpi_rs1,
  output logic [XLEN-1:0] pcpi_rs2,
  output logic [XLEN-1:0] pcpi_rs3,
  input  logic            pcpi_wr,
  input  logic [XLEN-1:0] pcpi_rd,
  input  logic            pcpi_wait,
  input  logic            pcpi_ready,
`ifdef RVB_PCPI_MASTER_STATS_EN
  output logic [31:0]     stat_issued,
  output logic [31:0]     stat_illegal,
  output logic [31:0]     stat_wait_cycles,
`endif
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rd,
  output logic            rsp_wr,
  output logic            rsp_illegal
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] insn_q, insn_d;
  logic [XLEN-1:0] rs1_q, rs1_d;
  logic [XLEN-1:0] rs2_q, rs2_d;
  logic [XLEN-1:0] rs3_q, rs3_d;
  rsp_t            rsp_q, rsp_d;

  logic in_issue;
  logic accept;
  logic expired;
  logic timeout;

  assign in_issue = (state_q == ISSUE);
  assign accept   = (state_q == IDLE) && req_valid;
  // A coprocessor answer in the expiry cycle takes priority over the timeout.
  assign timeout  = expired && !pcpi_ready;

  rvb_pcpi_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .resetn  (resetn),
    .run     (in_issue),
    .clear   (pcpi_wait),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = ISSUE;
      ISSUE:   if (pcpi_ready || expired) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = 1'b0;
    pcpi_valid = 1'b0;
    rsp_valid  = 1'b0;
    case (state_q)
      IDLE:    req_ready  = 1'b1;
      ISSUE:   pcpi_valid = 1'b1;
      RESP:    rsp_valid  = 1'b1;
      default: req_ready  = 1'b0;
    endcase
  end

  always_comb begin
    insn_d = insn_q;
    rs1_d  = rs1_q;
    rs2_d  = rs2_q;
    rs3_d  = rs3_q;
    rsp_d  = rsp_q;
    if (accept) begin
      insn_d = req_insn;
      rs1_d  = req_rs1;
      rs2_d  = req_rs2;
      rs3_d  = req_rs3;
    end
    if (in_issue && pcpi_ready) begin
      rsp_d.rd      = pcpi_rd;
      rsp_d.wr      = pcpi_wr;
      rsp_d.illegal = 1'b0;
    end else if (in_issue && timeout) begin
      rsp_d.rd      = '0;
      rsp_d.wr      = 1'b0;
      rsp_d.illegal = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      insn_q <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
      rs3_q  <= '0;
      rsp_q  <= '0;
    end else begin
      insn_q <= insn_d;
      rs1_q  <= rs1_d;
      rs2_q  <= rs2_d;
      rs3_q  <= rs3_d;
      rsp_q  <= rsp_d;
    end
  end

  assign pcpi_insn   = insn_q;
  assign pcpi_rs1    = rs1_q;
  assign pcpi_rs2    = rs2_q;
  assign pcpi_rs3    = rs3_q;
  assign rsp_rd      = rsp_q.rd;
  assign rsp_wr      = rsp_q.wr;
  assign rsp_illegal = rsp_q.illegal;

`ifdef RVB_PCPI_MASTER_STATS_EN
  logic [31:0] issued_q, issued_d;
  logic [31:0] illegal_q, illegal_d;
  logic [31:0] wait_q, wait_d;

  always_comb begin
    issued_d  = issued_q  + {31'd0, accept};
    illegal_d = illegal_q + {31'd0, in_issue && timeout};
    wait_d    = wait_q    + {31'd0, in_issue && pcpi_wait};
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      issued_q  <= '0;
      illegal_q <= '0;
      wait_q    <= '0;
    end else begin
      issued_q  <= issued_d;
      illegal_q <= illegal_d;
      wait_q    <= wait_d;
    end
  end

  assign stat_issued      = issued_q;
  assign stat_illegal     = illegal_q;
  assign stat_wait_cycles = wait_q;
`endif

endmodule

`default_nettype wire
